// File: rtl/dmem_loader.sv
// dmem_loader
//
// Byte-stream loader/dumper in front of the 256x8 data memory. It owns the
// memory's single address/write port: in IDLE the core's request passes
// straight through; once a transfer is started the loader drives the port and
// either writes an incoming byte stream to consecutive addresses (LOAD) or
// reads consecutive addresses out on a byte stream (DUMP).
//
// Handshake semantics (both streams): a beat transfers at a rising edge of Clk
// where valid and ready are both high. Valid, once raised by a producer, stays
// high and its data stays stable until the beat transfers. The loader holds
// InReady high for the whole LOAD phase and OutValid high for the whole DUMP
// phase, so for LOAD a beat is InValid alone and for DUMP a beat is OutReady
// alone.
//
// Ports
//   Clk, Reset                   clock, synchronous active-high reset
//   i_Start, i_Mode              transfer request (IDLE only); 0=LOAD, 1=DUMP
//   i_BaseAddr, i_Count          first address and byte count, latched with Start
//   i_InValid/i_InData/o_InReady     LOAD stream
//   o_OutValid/o_OutData/i_OutReady  DUMP stream
//   o_Busy, o_Done               transfer in progress / one-cycle completion
//   i_Core*                      core-side memory request
//   o_Mem*, i_MemDataOut         data memory port (combinational read data)
//   o_State                      current FSM state, for debug and checkers

module dmem_loader #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         i_Start,
  input  logic         i_Mode,
  input  logic [A-1:0] i_BaseAddr,
  input  logic [A:0]   i_Count,
  input  logic         i_InValid,
  input  logic [W-1:0] i_InData,
  output logic         o_InReady,
  output logic         o_OutValid,
  output logic [W-1:0] o_OutData,
  input  logic         i_OutReady,
  output logic         o_Busy,
  output logic         o_Done,
  input  logic         i_CoreWriteEn,
  input  logic [A-1:0] i_CoreAddr,
  input  logic [W-1:0] i_CoreDataIn,
  output logic         o_MemWriteEn,
  output logic [A-1:0] o_MemAddr,
  output logic [W-1:0] o_MemDataIn,
  input  logic [W-1:0] i_MemDataOut,
  output logic [1:0]   o_State
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DUMP   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // One full pass over the memory; larger counts are clamped to this so no
  // address is ever visited twice in one transfer.
  localparam logic [A:0] FULL_COUNT = {1'b1, {A{1'b0}}};

  state_t       r_state;
  state_t       w_next_state;
  logic [A-1:0] r_addr;
  logic [A:0]   r_remaining;
  logic         w_accept;
  logic         w_beat;
  logic         w_last;

  assign w_accept = (r_state == S_IDLE) && i_Start;
  assign w_beat   = ((r_state == S_LOAD) && i_InValid) ||
                    ((r_state == S_DUMP) && i_OutReady);
  assign w_last   = w_beat && (r_remaining == (A+1)'(1));

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_Start) begin
          if (i_Count == '0) begin
            w_next_state = S_FINISH;
          end else if (i_Mode) begin
            w_next_state = S_DUMP;
          end else begin
            w_next_state = S_LOAD;
          end
        end
      end
      S_LOAD, S_DUMP: begin
        if (w_last) begin
          w_next_state = S_FINISH;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Address pointer and beat counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_addr      <= i_BaseAddr;
      r_remaining <= (i_Count > FULL_COUNT) ? FULL_COUNT : i_Count;
    end else if (w_beat) begin
      r_addr      <= r_addr + (A)'(1);
      r_remaining <= r_remaining - (A+1)'(1);
    end
  end

  // Output logic
  always_comb begin
    o_InReady    = 1'b0;
    o_OutValid   = 1'b0;
    o_Busy       = 1'b0;
    o_Done       = 1'b0;
    o_MemWriteEn = 1'b0;
    o_MemAddr    = r_addr;
    o_MemDataIn  = i_InData;
    case (r_state)
      S_IDLE: begin
        o_MemWriteEn = i_CoreWriteEn;
        o_MemAddr    = i_CoreAddr;
        o_MemDataIn  = i_CoreDataIn;
      end
      S_LOAD: begin
        o_InReady    = 1'b1;
        o_Busy       = 1'b1;
        o_MemWriteEn = i_InValid;
      end
      S_DUMP: begin
        o_OutValid = 1'b1;
        o_Busy     = 1'b1;
      end
      S_FINISH: begin
        o_Busy = 1'b1;
        o_Done = 1'b1;
      end
      default: begin
        o_Busy = 1'b0;
      end
    endcase
    // Reset is synchronous, so the state may still be active during the reset
    // cycle; mask everything so the memory's reset preload is never disturbed
    // and an aborted transfer shows neither Busy nor Done.
    if (Reset) begin
      o_InReady    = 1'b0;
      o_OutValid   = 1'b0;
      o_Busy       = 1'b0;
      o_Done       = 1'b0;
      o_MemWriteEn = 1'b0;
    end
  end

  // Zero read latency: the memory read data for r_addr is the stream data.
  assign o_OutData = i_MemDataOut;
  assign o_State   = r_state;

endmodule

// File: tb/tb_dmem_loader.sv
module tb_dmem_loader;

  localparam int W = 8;
  localparam int A = 8;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic         Reset;
  logic         Start, Mode;
  logic [A-1:0] BaseAddr;
  logic [A:0]   Count;
  logic         InValid;
  logic [W-1:0] InData;
  logic         InReady;
  logic         OutValid;
  logic [W-1:0] OutData;
  logic         OutReady;
  logic         Busy, Done;
  logic         CoreWriteEn;
  logic [A-1:0] CoreAddr;
  logic [W-1:0] CoreDataIn;
  logic         MemWriteEn;
  logic [A-1:0] MemAddr;
  logic [W-1:0] MemDataIn;
  logic [W-1:0] MemDataOut;
  logic [1:0]   State;

  dmem_loader #(.W(W), .A(A)) dut (
    .Clk(Clk), .Reset(Reset),
    .i_Start(Start), .i_Mode(Mode), .i_BaseAddr(BaseAddr), .i_Count(Count),
    .i_InValid(InValid), .i_InData(InData), .o_InReady(InReady),
    .o_OutValid(OutValid), .o_OutData(OutData), .i_OutReady(OutReady),
    .o_Busy(Busy), .o_Done(Done),
    .i_CoreWriteEn(CoreWriteEn), .i_CoreAddr(CoreAddr), .i_CoreDataIn(CoreDataIn),
    .o_MemWriteEn(MemWriteEn), .o_MemAddr(MemAddr), .o_MemDataIn(MemDataIn),
    .i_MemDataOut(MemDataOut), .o_State(State)
  );

  // ---------------- data memory (256x8, combinational read) ----------------
  logic         tb_preload;
  logic [7:0]   mem [256];
  logic [7:0]   ref_mem [256];

  function automatic logic [7:0] init_val(input int i);
    case (i)
      128:     return 8'h01;
      129:     return 8'hFF;
      130:     return 8'h40;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  assign MemDataOut = mem[MemAddr];

  always @(posedge Clk) begin
    if (tb_preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (MemWriteEn) begin
      mem[MemAddr] <= MemDataIn;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] ld_q[$];
  bit         hs_pat[$];
  logic [7:0] dump_got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 256; i++)
      if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL %s: mem[%0h] got %0h expected %0h", name, bad, mem[bad], ref_mem[bad]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic core_write(input logic [7:0] addr, input logic [7:0] data);
    @(posedge Clk); #1;
    CoreWriteEn = 1'b1; CoreAddr = addr; CoreDataIn = data;
    @(negedge Clk);
    chk("pass_we", MemWriteEn, 1'b1);
    chk("pass_addr", MemAddr, addr);
    chk("pass_data", MemDataIn, data);
    ref_mem[addr] = data;
    @(posedge Clk); #1;
    CoreWriteEn = 1'b0;
  endtask

  // Runs one transfer. The reference model is transaction level: a pointer
  // and a beats-left count derived from the request; each accepted beat moves
  // one byte between the stream and ref_mem. restart_cyc re-raises Start in
  // that cycle (must be ignored); core_hold keeps a core write request active
  // while busy (must be dropped).
  task automatic run_xfer(input bit mode, input logic [7:0] base, input logic [8:0] count,
                          input int pct, input int restart_cyc, input bit core_hold,
                          output int done_cyc);
    int n, c;
    logic [7:0] ptr, d;
    bit hs;
    n = (count > 9'd256) ? 256 : int'(count);
    ptr = base;
    done_cyc = -1;
    exp_q.delete();
    dump_got.delete();
    if (mode) for (int k = 0; k < n; k++) exp_q.push_back(ref_mem[8'(int'(base) + k)]);
    @(posedge Clk); #1;
    Start = 1'b1; Mode = mode; BaseAddr = base; Count = count;
    InValid = 1'b0; OutReady = 1'b0;
    c = 0;
    while (1) begin
      @(posedge Clk); #1;
      c++;
      if (c == restart_cyc) begin
        Start = 1'b1; Mode = ~mode; BaseAddr = base + 8'h40; Count = 9'd5;
      end else begin
        Start = 1'b0;
      end
      if (c > 2000) begin
        chk("xfer_timeout", 32'(c), 32'(n));
        break;
      end
      if (n > 0) begin
        hs = (hs_pat.size() > 0) ? hs_pat.pop_front() : ($urandom_range(0, 99) < pct);
        d  = (ld_q.size() > 0) ? ld_q[0] : 8'($urandom_range(0, 255));
        if (mode) begin
          OutReady = hs; InValid = 1'($urandom_range(0, 1)); InData = 8'($urandom_range(0, 255));
        end else begin
          InValid = hs; InData = d; OutReady = 1'($urandom_range(0, 1));
        end
        if (core_hold) CoreWriteEn = 1'b1;
        @(negedge Clk);
        chk("xfer_busy", Busy, 1'b1);
        chk("xfer_done", Done, 1'b0);
        chk("xfer_addr", MemAddr, ptr);
        if (mode) begin
          chk("dump_valid", OutValid, 1'b1);
          chk("dump_inready", InReady, 1'b0);
          chk("dump_we", MemWriteEn, 1'b0);
          chk("dump_data", OutData, exp_q[0]);
        end else begin
          chk("load_ready", InReady, 1'b1);
          chk("load_outvalid", OutValid, 1'b0);
          chk("load_we", MemWriteEn, hs);
          chk("load_wdata", MemDataIn, d);
        end
        if (hs) begin
          if (mode) begin
            dump_got.push_back(OutData);
            void'(exp_q.pop_front());
          end else begin
            ref_mem[ptr] = d;
            if (ld_q.size() > 0) void'(ld_q.pop_front());
          end
          ptr = ptr + 8'd1;
          n--;
        end
      end else begin
        InValid = 1'b0; OutReady = 1'b0; CoreWriteEn = 1'b0;
        @(negedge Clk);
        chk("fin_done", Done, 1'b1);
        chk("fin_busy", Busy, 1'b1);
        chk("fin_we", MemWriteEn, 1'b0);
        chk("fin_inready", InReady, 1'b0);
        chk("fin_outvalid", OutValid, 1'b0);
        done_cyc = c;
        break;
      end
    end
    @(posedge Clk); #1;
    Start = 1'b0;
    @(negedge Clk);
    chk("idle_busy", Busy, 1'b0);
    chk("idle_done", Done, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         mode;
    logic [7:0] base;
    logic [8:0] count;
    int         exp_done;
  } vec_t;

  vec_t vecs[7];

  // ---------------- main sequence ----------------
  initial begin
    int dc;
    vecs[0] = '{1'b0, 8'h30, 9'd1,   2};
    vecs[1] = '{1'b1, 8'h30, 9'd1,   2};
    vecs[2] = '{1'b0, 8'hF0, 9'd20,  21};
    vecs[3] = '{1'b1, 8'hF8, 9'd12,  13};
    vecs[4] = '{1'b0, 8'h00, 9'd300, 257};
    vecs[5] = '{1'b1, 8'h80, 9'd256, 257};
    vecs[6] = '{1'b1, 8'h05, 9'd511, 257};

    Start = 0; Mode = 0; BaseAddr = 0; Count = 0; InValid = 0; InData = 0; OutReady = 0;
    tb_preload = 1'b1; Reset = 1'b1;
    CoreWriteEn = 1'b1; CoreAddr = 8'h80; CoreDataIn = 8'h00;
    repeat (2) @(posedge Clk);
    #1 tb_preload = 1'b0;
    @(negedge Clk);
    chk("rst_we", MemWriteEn, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_inready", InReady, 1'b0);
    chk("rst_outvalid", OutValid, 1'b0);
    chk("rst_outdata", OutData, 8'h01);
    @(posedge Clk); #1;
    Reset = 1'b0; CoreWriteEn = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(negedge Clk);
    check_mem("rst_preload");

    // IDLE pass-through
    core_write(8'h40, 8'h5A);
    @(negedge Clk);
    chk("pass_mem40", mem[8'h40], 8'h5A);

    // LOAD 0x10, 4 bytes continuous
    ld_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_xfer(1'b0, 8'h10, 9'd4, 100, -1, 1'b0, dc);
    chk("t1_done_cycle", 32'(dc), 32'd5);
    chk("t1_m10", mem[8'h10], 8'hA1);
    chk("t1_m11", mem[8'h11], 8'hB2);
    chk("t1_m12", mem[8'h12], 8'hC3);
    chk("t1_m13", mem[8'h13], 8'hD4);
    check_mem("t1_mem");

    // LOAD wrapping through 0xFF -> 0x00
    ld_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_xfer(1'b0, 8'hFE, 9'd4, 100, -1, 1'b0, dc);
    chk("t2_mFE", mem[8'hFE], 8'h01);
    chk("t2_mFF", mem[8'hFF], 8'h02);
    chk("t2_m00", mem[8'h00], 8'h03);
    chk("t2_m01", mem[8'h01], 8'h04);
    chk("t2_m02", mem[8'h02], init_val(2));

    // DUMP with stalls
    hs_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_xfer(1'b1, 8'h10, 9'd4, 100, -1, 1'b0, dc);
    chk("t3_done_cycle", 32'(dc), 32'd8);
    chk("t3_beats", 32'(dump_got.size()), 32'd4);
    if (dump_got.size() == 4) begin
      chk("t3_b0", dump_got[0], 8'hA1);
      chk("t3_b1", dump_got[1], 8'hB2);
      chk("t3_b2", dump_got[2], 8'hC3);
      chk("t3_b3", dump_got[3], 8'hD4);
    end

    // Count = 0, then a Start during Busy that must be ignored
    run_xfer(1'b0, 8'h50, 9'd0, 100, -1, 1'b0, dc);
    chk("t4_zero_done_cycle", 32'(dc), 32'd1);
    check_mem("t4_zero_mem");
    run_xfer(1'b0, 8'h60, 9'd3, 100, 2, 1'b0, dc);
    chk("t4_restart_done_cycle", 32'(dc), 32'd4);
    @(negedge Clk);
    chk("t4_restart_idle", Busy, 1'b0);
    check_mem("t4_restart_mem");

    // Reset after 2 of 4 LOAD beats
    @(posedge Clk); #1;
    Start = 1'b1; Mode = 1'b0; BaseAddr = 8'h20; Count = 9'd4;
    @(posedge Clk); #1;
    Start = 1'b0; InValid = 1'b1; InData = 8'h11;
    @(negedge Clk);
    chk("t5_ready1", InReady, 1'b1);
    ref_mem[8'h20] = 8'h11;
    @(posedge Clk); #1;
    InData = 8'h22;
    @(negedge Clk);
    chk("t5_ready2", InReady, 1'b1);
    ref_mem[8'h21] = 8'h22;
    @(posedge Clk); #1;
    Reset = 1'b1; InData = 8'h33;
    CoreWriteEn = 1'b1; CoreAddr = 8'h80; CoreDataIn = 8'h00;
    @(negedge Clk);
    chk("t5_rst_we", MemWriteEn, 1'b0);
    chk("t5_rst_busy", Busy, 1'b0);
    chk("t5_rst_done", Done, 1'b0);
    chk("t5_rst_ready", InReady, 1'b0);
    @(posedge Clk); #1;
    Reset = 1'b0; InValid = 1'b0; CoreWriteEn = 1'b0;
    @(negedge Clk);
    chk("t5_post_busy", Busy, 1'b0);
    chk("t5_post_done", Done, 1'b0);
    @(negedge Clk);
    chk("t5_post2_done", Done, 1'b0);
    check_mem("t5_mem");
    chk("t5_m80", mem[8'h80], 8'h01);
    chk("t5_m81", mem[8'h81], 8'hFF);
    chk("t5_m82", mem[8'h82], 8'h40);

    // Core write while Busy is dropped
    CoreAddr = 8'h40; CoreDataIn = 8'hEE;
    run_xfer(1'b0, 8'h70, 9'd3, 100, -1, 1'b1, dc);
    chk("t6_mem40", mem[8'h40], 8'h5A);
    check_mem("t6_mem");

    // Table-driven transfers with continuous handshakes
    for (int v = 0; v < 7; v++) begin
      run_xfer(vecs[v].mode, vecs[v].base, vecs[v].count, 100, -1, 1'b0, dc);
      chk($sformatf("vec%0d_done_cycle", v), 32'(dc), 32'(vecs[v].exp_done));
      check_mem($sformatf("vec%0d_mem", v));
    end

    // Randomised transfers with random stalls
    for (int r = 0; r < 25; r++) begin
      run_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               9'($urandom_range(0, 20)), 60, -1, 1'b0, dc);
      check_mem($sformatf("rand%0d_mem", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_loader.md
# dmem_loader

Byte-stream loader and dumper sitting directly upstream of the 256×8 data memory. It arbitrates the memory's single address/write port. When idle it passes the processor core's accesses through unchanged. When started, it takes ownership of the port and either writes an incoming valid/ready byte stream to consecutive addresses (LOAD) or reads consecutive addresses out on a valid/ready stream (DUMP). It is used to preload plaintext/ciphertext buffers before a program run and to extract results afterwards.

## Interface
- W, 8, data width; must match data memory W (fixed at 8).
- A, 8, address width; memory depth 2**A.

- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Mode  in  1  0 = LOAD, 1 = DUMP; sampled with Start.
- BaseAddr  in  A  first address of transfer; sampled with Start.
- Count  in  A+1  number of bytes; sampled with Start.
- InValid / InData / InReady  in / in W / out  LOAD stream.
- OutValid / OutData / OutReady  out / out W / in  DUMP stream.
- Busy  out  1  high from the cycle after accepted Start through the FINISH cycle.
- Done  out  1  one-cycle pulse in FINISH.
- CoreWriteEn, CoreAddr[A-1:0], CoreDataIn[W-1:0]  in  core-side memory request.
- MemWriteEn, MemAddr[A-1:0], MemDataIn[W-1:0]  out  to data memory.
- MemDataOut  in  W  combinational read data from data memory.

## Operation
- States: IDLE, LOAD, DUMP, FINISH.
- Registers: addr (A bits) and remaining (A+1 bits).
- IDLE:
  - Mem* = Core* pass-through.
  - InReady = 0, OutValid = 0, Busy = 0.
  - On Start: latch addr = BaseAddr and remaining = min(Count, 2**A).
  - Count = 0 → FINISH. Otherwise Mode = 0 → LOAD, Mode = 1 → DUMP.
- LOAD:
  - InReady = 1, MemAddr = addr, MemDataIn = InData, MemWriteEn = InValid.
  - On InValid: write occurs at that edge; addr += 1 (mod 2**A, wraps FF→00); remaining -= 1.
  - When remaining reaches 0 → FINISH.
- DUMP:
  - MemAddr = addr, MemWriteEn = 0, OutValid = 1, OutData = MemDataOut.
  - On OutReady: addr += 1 (wraps); remaining -= 1; last beat → FINISH.
  - While OutReady = 0, OutData is held stable because addr does not change.
- FINISH:
  - Done = 1 and Busy = 1 for exactly one cycle, then → IDLE.
  - MemWriteEn = 0. Mem port is released to the core in the following cycle.
- Core accesses issued while Busy are dropped; no queuing. Core side must not access memory while Busy.
- Start while Busy is ignored.
- Count > 2**A saturates to 2**A (one full memory pass; no address revisited).
- Reset:
  - State → IDLE; addr and remaining → 0.
  - Outputs: InReady = 0, OutValid = 0, Busy = 0, Done = 0, OutData = MemDataOut (don't-care).
  - MemWriteEn = 0 while Reset is high, regardless of CoreWriteEn, so the memory's reset preload is not disturbed.
  - Reset mid-transfer aborts it: no Done pulse; bytes already written stay written.

## Timing
- Start high at edge 0 → Busy = 1 and InReady/OutValid = 1 in cycle 1.
- LOAD with InValid held high: one byte per cycle. N bytes occupy cycles 1..N, FINISH at cycle N+1, IDLE at cycle N+2. Total N+2 cycles from Start to pass-through.
- Count = 0: FINISH at cycle 1, IDLE at cycle 2; no memory write.
- DUMP read latency is 0. Beat k presents mem[BaseAddr+k] in the same cycle addr points to it.
- The memory write for a LOAD beat lands at the same edge as the handshake. A DUMP of that address starting afterwards sees the new data.

## Test plan
- LOAD Base = 0x10, Count = 4, bytes A1 B2 C3 D4 with InValid continuous → mem[10..13] = A1 B2 C3 D4; Done pulses in cycle 5; Busy low at cycle 6.
- LOAD Base = 0xFE, Count = 4, bytes 01 02 03 04 → mem[FE] = 01, mem[FF] = 02, mem[00] = 03, mem[01] = 04 (wrap); mem[02] unchanged.
- DUMP Base = 0x10, Count = 4 after first test, OutReady toggling 1,0,0,1,1,0,1 → output sequence A1 B2 C3 D4; OutData stable during stalls; Done after the 4th accept.
- Start with Count = 0 → Done in cycle 1, no MemWriteEn; second Start issued during Busy of a Count = 3 LOAD is ignored.
- Reset asserted after 2 of 4 LOAD beats (Base = 0x20) → Busy = 0 next cycle, no Done; mem[20..21] written, mem[22..23] unchanged; mem[128..130] = 01, FF, 40 after Reset.
- IDLE pass-through: CoreWriteEn = 1, CoreAddr = 0x40, CoreDataIn = 5A → mem[40] = 5A; the same request issued while Busy leaves mem[40] unchanged.
